// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// A clock-enable divider paces horizontal/vertical counters; sync, data-enable,
// coordinates and line/frame strobes are registered from the post-increment
// counter values so they all change together, one clock after the enable.
// Optional colour-bar test pattern: define VGA_TIMING_TESTPAT_EN.
module vga_timing_gen #(
    parameter int DIV      = 5,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int XW      = $clog2(H_TOTAL),
    localparam int YW      = $clog2(V_TOTAL)
) (
    input  logic          iCLK,
    input  logic          iRESET,
    output logic          oPIX_CE,
    output logic          oHS,
    output logic          oVS,
    output logic          oDE,
    output logic [XW-1:0] oX,
    output logic [YW-1:0] oY,
    output logic          oLINE_START,
`ifdef VGA_TIMING_TESTPAT_EN
    output logic [7:0]    oRED,
    output logic [7:0]    oGRN,
    output logic [7:0]    oBLU,
`endif
    output logic          oFRAME_START
);

    // Bad geometry or divider would give a broken raster; refuse to build it.
    if (DIV < 1 || H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_params
        $error("vga_timing_gen: illegal DIV or zero-length timing interval");
    end

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT    = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_BEGIN = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_ACT    = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_BEGIN = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    logic [DW-1:0] r_div_cnt;
    logic [XW-1:0] r_h_cnt;
    logic [YW-1:0] r_v_cnt;
    logic          r_pix_ce;
    logic          r_hs;
    logic          r_vs;
    logic          r_de;
    logic          r_line_start;
    logic          r_frame_start;

    logic          w_ce;
    logic          w_h_wrap;
    logic [XW-1:0] w_h_next;
    logic [YW-1:0] w_v_next;
    logic          w_de_next;
    logic          w_hs_act;
    logic          w_vs_act;

    assign w_ce     = (r_div_cnt == DIV_LAST);
    assign w_h_wrap = w_ce && (r_h_cnt == H_LAST);

    // Post-increment counter values; outputs are decoded from these so they
    // land in the same edge as the counters themselves.
    always_comb begin
        w_h_next = r_h_cnt;
        w_v_next = r_v_cnt;
        if (w_ce) begin
            w_h_next = w_h_wrap ? '0 : r_h_cnt + XW'(1);
        end
        if (w_h_wrap) begin
            w_v_next = (r_v_cnt == V_LAST) ? '0 : r_v_cnt + YW'(1);
        end
    end

    assign w_de_next = (w_h_next < H_ACT) && (w_v_next < V_ACT);
    assign w_hs_act  = (w_h_next >= HS_BEGIN) && (w_h_next < HS_END);
    assign w_vs_act  = (w_v_next >= VS_BEGIN) && (w_v_next < VS_END);

`ifdef VGA_TIMING_TESTPAT_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0] w_bar;
    logic [7:0] r_red;
    logic [7:0] r_grn;
    logic [7:0] r_blu;

    // Bar index by threshold compare; avoids a divider on the pixel path.
    always_comb begin
        w_bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (w_h_next >= XW'(k * BAR_W)) begin
                w_bar = 3'(k);
            end
        end
    end

    // Bars run white, yellow, cyan, green, magenta, red, blue, black, which
    // maps each channel onto one inverted bit of the bar index.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            r_red <= 8'h00;
            r_grn <= 8'h00;
            r_blu <= 8'h00;
        end else if (w_ce) begin
            r_red <= (w_de_next && !w_bar[1]) ? 8'hFF : 8'h00;
            r_grn <= (w_de_next && !w_bar[2]) ? 8'hFF : 8'h00;
            r_blu <= (w_de_next && !w_bar[0]) ? 8'hFF : 8'h00;
        end
    end

    assign oRED = r_red;
    assign oGRN = r_grn;
    assign oBLU = r_blu;
`endif

    // Divider, raster counters and registered decode; decode only moves on ce
    // so the reset values hold until the first pixel.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            r_div_cnt     <= '0;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_pix_ce      <= 1'b0;
            r_hs          <= !HS_ON;
            r_vs          <= !VS_ON;
            r_de          <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_div_cnt     <= w_ce ? '0 : r_div_cnt + DW'(1);
            r_h_cnt       <= w_h_next;
            r_v_cnt       <= w_v_next;
            r_pix_ce      <= w_ce;
            r_line_start  <= w_ce && (w_h_next == '0);
            r_frame_start <= w_ce && (w_h_next == '0) && (w_v_next == '0);
            if (w_ce) begin
                r_de <= w_de_next;
                r_hs <= w_hs_act ? HS_ON : !HS_ON;
                r_vs <= w_vs_act ? VS_ON : !VS_ON;
            end
        end
    end

    assign oPIX_CE      = r_pix_ce;
    assign oHS          = r_hs;
    assign oVS          = r_vs;
    assign oDE          = r_de;
    assign oX           = r_h_cnt;
    assign oY           = r_v_cnt;
    assign oLINE_START  = r_line_start;
    assign oFRAME_START = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (small DIV=3 raster, small DIV=1
// raster with positive syncs, default 640x480) share one clock and reset.
// Expected outputs come from a closed-form model indexed by clocks since reset.
module tb_vga_timing_gen;

    typedef struct packed {
        logic        pce;
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] x;
        logic [11:0] y;
        logic        ls;
        logic        fs;
        logic [23:0] rgb;
    } exp_t;

    logic clk_sys;
    logic iRESET;

    logic       a_pce, a_hs, a_vs, a_de, a_ls, a_fs;
    logic [4:0] a_x;
    logic [3:0] a_y;
    logic       b_pce, b_hs, b_vs, b_de, b_ls, b_fs;
    logic [4:0] b_x;
    logic [3:0] b_y;
    logic       c_pce, c_hs, c_vs, c_de, c_ls, c_fs;
    logic [9:0] c_x;
    logic [9:0] c_y;
`ifdef VGA_TIMING_TESTPAT_EN
    logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b;
`endif

    int   n_vec;
    int   n_miss;
    int   cyc;
    int   k_clk;
    exp_t sb_q[$];

    int   a_last_fs;
    int   a_de_acc;
    int   a_fs_gap;
    int   a_de_frame;

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    vga_timing_gen #(
        .DIV(3), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(0), .VS_POL(0)
    ) u_a (
        .iCLK(clk_sys), .iRESET(iRESET), .oPIX_CE(a_pce), .oHS(a_hs), .oVS(a_vs),
        .oDE(a_de), .oX(a_x), .oY(a_y), .oLINE_START(a_ls),
`ifdef VGA_TIMING_TESTPAT_EN
        .oRED(a_r), .oGRN(a_g), .oBLU(a_b),
`endif
        .oFRAME_START(a_fs)
    );

    vga_timing_gen #(
        .DIV(1), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1), .VS_POL(1)
    ) u_b (
        .iCLK(clk_sys), .iRESET(iRESET), .oPIX_CE(b_pce), .oHS(b_hs), .oVS(b_vs),
        .oDE(b_de), .oX(b_x), .oY(b_y), .oLINE_START(b_ls),
`ifdef VGA_TIMING_TESTPAT_EN
        .oRED(b_r), .oGRN(b_g), .oBLU(b_b),
`endif
        .oFRAME_START(b_fs)
    );

    vga_timing_gen u_c (
        .iCLK(clk_sys), .iRESET(iRESET), .oPIX_CE(c_pce), .oHS(c_hs), .oVS(c_vs),
        .oDE(c_de), .oX(c_x), .oY(c_y), .oLINE_START(c_ls),
`ifdef VGA_TIMING_TESTPAT_EN
        .oRED(c_r), .oGRN(c_g), .oBLU(c_b),
`endif
        .oFRAME_START(c_fs)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Closed form: after k un-reset clocks, p = k/div pixels have elapsed.
    function automatic exp_t model(input int k, input int div,
                                   input int ha, input int hf, input int hs, input int hb,
                                   input int va, input int vf, input int vs, input int vb,
                                   input int hpol, input int vpol);
        exp_t e;
        int   ht, vt, p, x, y, bar;
        logic [23:0] bars [8];
        bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
        bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        p  = k / div;
        x  = p % ht;
        y  = (p / ht) % vt;
        e.pce = (k > 0) && (k % div == 0);
        e.x   = 12'(x);
        e.y   = 12'(y);
        if (p == 0) begin
            e.de = 1'b0;
            e.hs = (hpol == 0);
            e.vs = (vpol == 0);
        end else begin
            e.de = (x < ha) && (y < va);
            e.hs = ((x >= ha + hf) && (x < ha + hf + hs)) ? (hpol != 0) : (hpol == 0);
            e.vs = ((y >= va + vf) && (y < va + vf + vs)) ? (vpol != 0) : (vpol == 0);
        end
        e.ls  = e.pce && (x == 0);
        e.fs  = e.ls && (y == 0);
        bar   = x / (ha / 8);
        if (bar > 7) bar = 7;
        e.rgb = e.de ? bars[bar] : 24'h0;
        return e;
    endfunction

    task automatic cmp(input string inst, input exp_t e,
                       input logic pce, input logic hs, input logic vs, input logic de,
                       input logic [11:0] x, input logic [11:0] y,
                       input logic ls, input logic fs, input logic [23:0] rgb);
        check_val({inst, ".pix_ce"},      32'(pce), 32'(e.pce));
        check_val({inst, ".hs"},          32'(hs),  32'(e.hs));
        check_val({inst, ".vs"},          32'(vs),  32'(e.vs));
        check_val({inst, ".de"},          32'(de),  32'(e.de));
        check_val({inst, ".x"},           32'(x),   32'(e.x));
        check_val({inst, ".y"},           32'(y),   32'(e.y));
        check_val({inst, ".line_start"},  32'(ls),  32'(e.ls));
        check_val({inst, ".frame_start"}, 32'(fs),  32'(e.fs));
`ifdef VGA_TIMING_TESTPAT_EN
        check_val({inst, ".rgb"},         32'(rgb), 32'(e.rgb));
`else
        if (rgb !== 24'h0) $display("unexpected rgb %0h", rgb);
`endif
    endtask

    // One clock: drive reset, push the expectation for this edge, then compare
    // on the falling edge.
    task automatic step(input logic rst);
        exp_t e;
        logic [23:0] rgb_a, rgb_b, rgb_c;
        iRESET = rst;
        k_clk  = rst ? 0 : k_clk + 1;
        sb_q.push_back(model(k_clk, 3, 16, 2, 3, 3, 6, 1, 2, 1, 0, 0));
        sb_q.push_back(model(k_clk, 1, 16, 2, 3, 3, 6, 1, 2, 1, 1, 1));
        sb_q.push_back(model(k_clk, 5, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0));
        @(posedge clk_sys);
        @(negedge clk_sys);
        cyc++;
`ifdef VGA_TIMING_TESTPAT_EN
        rgb_a = {a_r, a_g, a_b};
        rgb_b = {b_r, b_g, b_b};
        rgb_c = {c_r, c_g, c_b};
`else
        rgb_a = 24'h0;
        rgb_b = 24'h0;
        rgb_c = 24'h0;
`endif
        e = sb_q.pop_front();
        cmp("a", e, a_pce, a_hs, a_vs, a_de, 12'(a_x), 12'(a_y), a_ls, a_fs, rgb_a);
        e = sb_q.pop_front();
        cmp("b", e, b_pce, b_hs, b_vs, b_de, 12'(b_x), 12'(b_y), b_ls, b_fs, rgb_b);
        e = sb_q.pop_front();
        cmp("c", e, c_pce, c_hs, c_vs, c_de, 12'(c_x), 12'(c_y), c_ls, c_fs, rgb_c);

        if (rst) begin
            a_last_fs = -1;
            a_de_acc  = 0;
        end else begin
            if (a_fs) begin
                if (a_last_fs >= 0) begin
                    a_fs_gap   = cyc - a_last_fs;
                    a_de_frame = a_de_acc;
                end
                a_last_fs = cyc;
                a_de_acc  = 0;
            end
            if (a_pce && a_de) a_de_acc++;
        end
    endtask

    initial begin
        n_vec      = 0;
        n_miss     = 0;
        cyc        = 0;
        k_clk      = 0;
        a_last_fs  = -1;
        a_de_acc   = 0;
        a_fs_gap   = 0;
        a_de_frame = 0;
        iRESET     = 1'b1;
        @(negedge clk_sys);
        for (int i = 0; i < 3; i++) step(1'b1);
        for (int i = 0; i < 4500; i++) step(1'b0);
        step(1'b1);
        for (int i = 0; i < 2500; i++) step(1'b0);
        check_val("a.frame_gap_clocks", 32'(a_fs_gap), 32'd720);
        check_val("a.de_pixels_per_frame", 32'(a_de_frame), 32'd96);
        check_val("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
